control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the datapath. Steps a fetch/execute state machine (T0..T7), decodes
//  IR[31:27], and drives every datapath control strobe, one control step per Clock cycle.
//  It is the producer of the strobes that the datapath consumes, and it sits beside the datapath in the CPU top.
// PARAMETERS
//  OPW     5   opcode width (IR[31:27])
//  NSTEP   8   control steps per instruction (T0..T7)
// PORTS
//  Clock      in   1   system clock; all state changes on the rising edge
//  Reset      in   1   synchronous, active-high reset
//  IR         in   32  instruction register contents from the datapath
//  CON_FF     in   1   branch-condition flip-flop from the datapath
//  Stop       in   1   finish current instruction, then halt
//  Run        out  1   1 while executing; 0 in reset or halt
//  PCout,Zhighout,Zlowout,MDRout,HIout,LOout,BAout,InPortout,Cout   out 1 each  bus drive selects
//  MARin,Zin,PCin,MDRin,IRin,Yin,HIin,LOin,OutPortin,CONin          out 1 each  register loads
//  Gra,Grb,Grc,Rin,Rout,IncPC,Read,Write                            out 1 each  reg-file / memory
//  AluOp      out  5   ALU function for Zin steps; 00011 (add) for address and branch arithmetic
// BEHAVIOUR
//  - Moore machine: every strobe is decoded from the registered state and the opcode only. Strobes are
//    valid for the whole step cycle, and datapath registers capture at the rising edge that ends the step.
//  - States: S_RST, T0..T7, S_HALT. Reset=1 at an edge -> S_RST (all outputs 0, Run=0); next edge -> T0.
//    Reset mid-instruction aborts the instruction, and no Write or Rin is issued after the reset edge.
//  - Fetch: T0 PCout MARin IncPC | T1 Read MDRin | T2 MDRout IRin. The IR is decoded from T3 onward.
//  - ld  00000: T3 Grb BAout Yin | T4 Cout Zin | T5 Zlowout MARin | T6 Read MDRin | T7 MDRout Gra Rin
//  - ldi 00001: T3 Grb BAout Yin | T4 Cout Zin | T5 Zlowout Gra Rin
//  - st  00010: T3-T5 as ld | T6 Gra Rout MDRin (Read=0, so MDR loads from the bus) | T7 Write
//  - 3-reg ALU 00011-01011 and mul/div 10000/01111:
//      3-reg ALU: T3 Grb Rout Yin | T4 Grc Rout Zin AluOp=opcode | T5 Zlowout Gra Rin
//      mul/div:   T3 Gra Rout Yin | T4 Grb Rout Zin AluOp=opcode | T5 Zlowout LOin | T6 Zhighout HIin
//  - addi/andi/ori 01100-01110: T3 Grb Rout Yin | T4 Cout Zin AluOp=opcode | T5 Zlowout Gra Rin
//  - neg/not 10001/10010: T3 Grb Rout Zin AluOp=opcode | T4 Zlowout Gra Rin
//  - br 10011: T3 Gra Rout CONin | T4 PCout Yin | T5 Cout Zin | T6 Zlowout PCin only if CON_FF=1
//    (T6 is still spent, with no strobes, when CON_FF=0)
//  - jr 10100: T3 Gra Rout PCin. in 10110: T3 InPortout Gra Rin. out 10111: T3 Gra Rout OutPortin.
//  - mfhi 11000: T3 HIout Gra Rin. mflo 11001: T3 LOout Gra Rin.
//  - nop 11010, and any undefined opcode: no T3 strobes; return to T0.
//  - halt 11011: T3 -> S_HALT. All strobes 0 and Run=0 until Reset.
//  - After an instruction's last step the next state is T0, or S_HALT if Stop has been sampled high at any
//    edge since that instruction's T0. Stop never truncates an in-flight instruction.
//  - AluOp = 00011 in every state not listed above (don't-care to the datapath, but fixed for determinism).
//  - Two or more bus drivers are never asserted in the same step; a bench assertion must enforce this.
// STRUCTURE
//  - cpu_defs.vh (shared include) holds:
//      opcode localparams (OP_LD..OP_HALT)
//      state encodings (S_RST, T0..T7, S_HALT; 4 bits)
//      the op-class enum.
//  - Sub-module op_class_decode: combinational, opcode[4:0] -> op class
//    (LD, LDI, ST, ALU3, ALUI, MULDIV, UNARY, BR, JR, IN, OUT, MFHI, MFLO, NOP, HALT).
//  - Top module: state register plus step counter, Stop latch, and the strobe decode table.
// TESTING
//  - Reset 1 cycle, IR=ldi R2,0x5(R0) (0x09000005) -> S_RST outputs 0; T0..T5 strobes as listed;
//    T5 has Zlowout,Gra,Rin=1; next state T0.
//  - ld R1,0x10(R3) (0x00980010) -> 8 steps; Read=1 in T1 and T6 only; Gra,Rin=1 only in T7.
//  - st 0x20(R1),R4 (0x12080020) -> Write=1 exactly once, in T7; Rin never asserted.
//  - br with CON_FF=0 then CON_FF=1 -> PCin absent in T6, then present in T6; both take 7 cycles.
//  - Reset asserted during T4 of add -> next cycle all outputs 0, then T0; no Rin pulse seen.
//  - Stop pulsed in T3 of mul -> T5 LOin and T6 HIin still occur, then S_HALT with Run=0.
//    A halt opcode -> Run=0 permanently until Reset.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, step states,
// instruction classes and the per-step strobe bundle.
package control_sequencer_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_OR   = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU3, C_ALUI, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } op_class_t;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, ba_out, inport_out, c_out;
    logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outport_in, con_in;
    logic gra, grb, grc, r_in, r_out, inc_pc, read, write;
  } strobes_t;

  // Final control step of each instruction class; fetch always runs T0..T2.
  function automatic state_t last_step(input op_class_t c);
    case (c)
      C_LD, C_ST:                 return T7;
      C_LDI, C_ALU3, C_ALUI:      return T5;
      C_MULDIV, C_BR:             return T6;
      C_UNARY:                    return T4;
      default:                    return T3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_op_class_decode.sv
// Combinational opcode classifier; undefined opcodes fall into the nop class.
module control_sequencer_op_class_decode
  import control_sequencer_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class
);

  always_comb begin
    op_class = C_NOP;
    case (opcode) inside
      OP_LD:             op_class = C_LD;
      OP_LDI:            op_class = C_LDI;
      OP_ST:             op_class = C_ST;
      [OP_ADD:OP_OR]:    op_class = C_ALU3;
      [OP_ADDI:OP_ORI]:  op_class = C_ALUI;
      OP_DIV, OP_MUL:    op_class = C_MULDIV;
      OP_NEG, OP_NOT:    op_class = C_UNARY;
      OP_BR:             op_class = C_BR;
      OP_JR:             op_class = C_JR;
      OP_IN:             op_class = C_IN;
      OP_OUT:            op_class = C_OUT;
      OP_MFHI:           op_class = C_MFHI;
      OP_MFLO:           op_class = C_MFLO;
      OP_NOP:            op_class = C_NOP;
      OP_HALT:           op_class = C_HALT;
      default:           op_class = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: steps T0..T7 per instruction and decodes every
// datapath strobe from the registered step and the IR opcode.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic           Clock,
  input  logic           Reset,
  input  logic [31:0]    IR,
  input  logic           CON_FF,
  input  logic           Stop,
  output logic           Run,
  output logic           PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
  output logic           MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin,
  output logic           Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write,
  output logic [OPW-1:0] AluOp
);

  state_t    state, state_nxt;
  logic      stop_seen;
  op_class_t op_class;
  strobes_t  s;
  logic      unused_ir_bits;

  // Only the opcode field steers the sequencer; operand fields belong to the datapath.
  assign unused_ir_bits = ^IR[26:0];

  control_sequencer_op_class_decode u_decode (
    .opcode   (IR[31:27]),
    .op_class (op_class)
  );

  // NOTE: non-blocking assignments for every registered signal so all state updates together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_RST;
      stop_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      stop_seen <= (state == T0) ? Stop : (stop_seen | Stop);
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    Run       = 1'b0;
    AluOp     = OP_ADD;
    s         = '0;

    case (state)
      S_RST:  begin AluOp = '0; state_nxt = T0; end
      S_HALT: ;
      default: begin
        Run = 1'b1;
        if (state == last_step(op_class))
          state_nxt = (op_class == C_HALT || stop_seen || Stop) ? S_HALT : T0;
        else
          state_nxt = state_t'(state + 4'd1);
      end
    endcase

    case (state)
      T0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; end
      T1: begin s.read = 1'b1; s.mdr_in = 1'b1; end
      T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
      T3, T4, T5, T6, T7: begin
        case (op_class)
          C_LD, C_LDI, C_ST:
            case (state)
              T3: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
              T4: begin s.c_out = 1'b1; s.z_in = 1'b1; end
              T5: begin
                s.zlow_out = 1'b1;
                if (op_class == C_LDI) begin s.gra = 1'b1; s.r_in = 1'b1; end
                else s.mar_in = 1'b1;
              end
              T6: begin
                s.mdr_in = 1'b1;
                if (op_class == C_ST) begin s.gra = 1'b1; s.r_out = 1'b1; end
                else s.read = 1'b1;
              end
              T7: begin
                if (op_class == C_ST) s.write = 1'b1;
                else begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
              end
              default: ;
            endcase
          C_ALU3, C_ALUI:
            case (state)
              T3: begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
              T4: begin
                s.z_in = 1'b1;
                AluOp  = IR[31:27];
                if (op_class == C_ALU3) begin s.grc = 1'b1; s.r_out = 1'b1; end
                else s.c_out = 1'b1;
              end
              T5: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
              default: ;
            endcase
          C_MULDIV:
            case (state)
              T3: begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
              T4: begin s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; AluOp = IR[31:27]; end
              T5: begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
              T6: begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
              default: ;
            endcase
          C_UNARY:
            case (state)
              T3: begin s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; AluOp = IR[31:27]; end
              T4: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
              default: ;
            endcase
          C_BR:
            case (state)
              T3: begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
              T4: begin s.pc_out = 1'b1; s.y_in = 1'b1; end
              T5: begin s.c_out = 1'b1; s.z_in = 1'b1; end
              T6: if (CON_FF) begin s.zlow_out = 1'b1; s.pc_in = 1'b1; end
              default: ;
            endcase
          C_JR:   if (state == T3) begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
          C_IN:   if (state == T3) begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          C_OUT:  if (state == T3) begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; end
          C_MFHI: if (state == T3) begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          C_MFLO: if (state == T3) begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign PCout     = s.pc_out;
  assign Zhighout  = s.zhigh_out;
  assign Zlowout   = s.zlow_out;
  assign MDRout    = s.mdr_out;
  assign HIout     = s.hi_out;
  assign LOout     = s.lo_out;
  assign BAout     = s.ba_out;
  assign InPortout = s.inport_out;
  assign Cout      = s.c_out;
  assign MARin     = s.mar_in;
  assign Zin       = s.z_in;
  assign PCin      = s.pc_in;
  assign MDRin     = s.mdr_in;
  assign IRin      = s.ir_in;
  assign Yin       = s.y_in;
  assign HIin      = s.hi_in;
  assign LOin      = s.lo_in;
  assign OutPortin = s.outport_in;
  assign CONin     = s.con_in;
  assign Gra       = s.gra;
  assign Grb       = s.grb;
  assign Grc       = s.grc;
  assign Rin       = s.r_in;
  assign Rout      = s.r_out;
  assign IncPC     = s.inc_pc;
  assign Read      = s.read;
  assign Write     = s.write;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instructions push per-step
// expectations; a negedge monitor pops and compares the full strobe word.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, CON_FF, Stop, Run;
  logic [31:0] IR;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin;
  logic        Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
  logic [4:0]  AluOp;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .BAout(BAout), .InPortout(InPortout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .IncPC(IncPC),
    .Read(Read), .Write(Write), .AluOp(AluOp)
  );

  always #5 Clock = ~Clock;

  localparam logic [26:0] PCOUT = 27'd1 << 0,  ZHIGH = 27'd1 << 1,  ZLOW  = 27'd1 << 2;
  localparam logic [26:0] MDROUT = 27'd1 << 3, HIOUT = 27'd1 << 4,  LOOUT = 27'd1 << 5;
  localparam logic [26:0] BAOUT = 27'd1 << 6,  INPORT = 27'd1 << 7, COUT  = 27'd1 << 8;
  localparam logic [26:0] MARIN = 27'd1 << 9,  ZIN   = 27'd1 << 10, PCIN  = 27'd1 << 11;
  localparam logic [26:0] MDRIN = 27'd1 << 12, IRIN  = 27'd1 << 13, YIN   = 27'd1 << 14;
  localparam logic [26:0] HIIN  = 27'd1 << 15, LOIN  = 27'd1 << 16, OUTPIN = 27'd1 << 17;
  localparam logic [26:0] CONIN = 27'd1 << 18, GRA   = 27'd1 << 19, GRB   = 27'd1 << 20;
  localparam logic [26:0] GRC   = 27'd1 << 21, RIN   = 27'd1 << 22, ROUT  = 27'd1 << 23;
  localparam logic [26:0] INCPC = 27'd1 << 24, READ  = 27'd1 << 25, WRITE = 27'd1 << 26;
  localparam logic [26:0] BUS_MASK = PCOUT | ZHIGH | ZLOW | MDROUT | HIOUT | LOOUT |
                                     BAOUT | INPORT | COUT | ROUT;

  localparam logic [32:0] RST_V  = 33'd0;
  localparam logic [32:0] HALT_V = {1'b0, 5'b00011, 27'd0};

  logic [32:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [32:0] ex(input logic [26:0] m);
    return {1'b1, 5'b00011, m};
  endfunction

  function automatic logic [32:0] exa(input logic [26:0] m, input logic [4:0] op);
    return {1'b1, op, m};
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (run|aluop|strobes)", name, act, exp);
    end
  endtask

  // Monitor: the control word is presented every step, so sample once per cycle mid-step.
  always @(negedge Clock) begin
    logic [26:0] strb;
    logic [32:0] obs;
    strb = {Write, Read, IncPC, Rout, Rin, Grc, Grb, Gra, CONin, OutPortin, LOin, HIin, Yin,
            IRin, MDRin, PCin, Zin, MARin, Cout, InPortout, BAout, LOout, HIout, MDRout,
            Zlowout, Zhighout, PCout};
    obs  = {Run, AluOp, strb};
    check("bus_single_driver", {32'd0, ($countones(strb & BUS_MASK) <= 1)}, 33'd1);
    if (exp_q.size() > 0) check(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  task automatic cyc(input string tag, input logic [32:0] e);
    @(posedge Clock);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Fetch steps; the next instruction's IR is presented once T0 has begun.
  task automatic fetch(input string nm, input logic [31:0] ir, input logic con);
    cyc({nm, ".T0"}, ex(PCOUT | MARIN | INCPC));
    IR     = ir;
    CON_FF = con;
    cyc({nm, ".T1"}, ex(READ | MDRIN));
    cyc({nm, ".T2"}, ex(MDROUT | IRIN));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset  = 1'b1;
    Stop   = 1'b0;
    CON_FF = 1'b0;
    IR     = 32'h0900_0005;
    cyc("reset", RST_V);
    Reset = 1'b0;

    // ldi R2,0x5(R0)
    cyc("ldi.T0", ex(PCOUT | MARIN | INCPC));
    cyc("ldi.T1", ex(READ | MDRIN));
    cyc("ldi.T2", ex(MDROUT | IRIN));
    cyc("ldi.T3", ex(GRB | BAOUT | YIN));
    cyc("ldi.T4", ex(COUT | ZIN));
    cyc("ldi.T5", ex(ZLOW | GRA | RIN));

    fetch("ld", 32'h0098_0010, 1'b0);
    cyc("ld.T3", ex(GRB | BAOUT | YIN));
    cyc("ld.T4", ex(COUT | ZIN));
    cyc("ld.T5", ex(ZLOW | MARIN));
    cyc("ld.T6", ex(READ | MDRIN));
    cyc("ld.T7", ex(MDROUT | GRA | RIN));

    fetch("st", 32'h1208_0020, 1'b0);
    cyc("st.T3", ex(GRB | BAOUT | YIN));
    cyc("st.T4", ex(COUT | ZIN));
    cyc("st.T5", ex(ZLOW | MARIN));
    cyc("st.T6", ex(GRA | ROUT | MDRIN));
    cyc("st.T7", ex(WRITE));

    fetch("br0", 32'h9880_0004, 1'b0);
    cyc("br0.T3", ex(GRA | ROUT | CONIN));
    cyc("br0.T4", ex(PCOUT | YIN));
    cyc("br0.T5", ex(COUT | ZIN));
    cyc("br0.T6", ex(27'd0));

    fetch("br1", 32'h9880_0004, 1'b1);
    cyc("br1.T3", ex(GRA | ROUT | CONIN));
    cyc("br1.T4", ex(PCOUT | YIN));
    cyc("br1.T5", ex(COUT | ZIN));
    cyc("br1.T6", ex(ZLOW | PCIN));

    fetch("sub", 32'h2091_8000, 1'b0);
    cyc("sub.T3", ex(GRB | ROUT | YIN));
    cyc("sub.T4", exa(GRC | ROUT | ZIN, 5'b00100));
    cyc("sub.T5", ex(ZLOW | GRA | RIN));

    fetch("addi", 32'h6088_0007, 1'b0);
    cyc("addi.T3", ex(GRB | ROUT | YIN));
    cyc("addi.T4", exa(COUT | ZIN, 5'b01100));
    cyc("addi.T5", ex(ZLOW | GRA | RIN));

    fetch("not", 32'h9088_0000, 1'b0);
    cyc("not.T3", exa(GRB | ROUT | ZIN, 5'b10010));
    cyc("not.T4", ex(ZLOW | GRA | RIN));

    fetch("in", 32'hB080_0000, 1'b0);
    cyc("in.T3", ex(INPORT | GRA | RIN));
    fetch("mfhi", 32'hC080_0000, 1'b0);
    cyc("mfhi.T3", ex(HIOUT | GRA | RIN));
    fetch("jr", 32'hA080_0000, 1'b0);
    cyc("jr.T3", ex(GRA | ROUT | PCIN));
    fetch("undef", 32'hE800_0000, 1'b0);
    cyc("undef.T3", ex(27'd0));

    // Reset during T4 of add aborts before the Rin step.
    fetch("add", 32'h1891_8000, 1'b0);
    cyc("add.T3", ex(GRB | ROUT | YIN));
    cyc("add.T4", exa(GRC | ROUT | ZIN, 5'b00011));
    Reset = 1'b1;
    cyc("add.abort", RST_V);
    Reset = 1'b0;

    // Stop seen during mul T3 lets mul finish, then halts.
    fetch("mul", 32'h8000_0000, 1'b0);
    cyc("mul.T3", ex(GRA | ROUT | YIN));
    Stop = 1'b1;
    cyc("mul.T4", exa(GRB | ROUT | ZIN, 5'b10000));
    Stop = 1'b0;
    cyc("mul.T5", ex(ZLOW | LOIN));
    cyc("mul.T6", ex(ZHIGH | HIIN));
    for (int i = 0; i < 3; i++) cyc("stop.halt", HALT_V);
    Reset = 1'b1;
    cyc("halt.reset", RST_V);
    Reset = 1'b0;

    fetch("halt", 32'hD800_0000, 1'b0);
    cyc("halt.T3", ex(27'd0));
    for (int i = 0; i < 4; i++) cyc("halt.hold", HALT_V);

    @(posedge Clock);
    @(posedge Clock);
    check("queue_drained", 33'(exp_q.size()), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
